// File: rtl/alu_mdu_pkg.sv
// -----------------------------------------------------------------------------
// alu_mdu_pkg
// Shared definitions for the alu_mdu execute unit:
//   - 5-bit opcodes for the base ALU group (opcode[4]=0) and the M group
//     (opcode[4]=1). Base codes keep their legacy 4-bit values, zero-extended.
//   - mdu_op_e: the 3-bit operation select seen by the iterative engine.
//   - Small helpers that classify an M operation by operand signedness.
// -----------------------------------------------------------------------------
package alu_mdu_pkg;

   // Base group
   localparam logic [4:0] OP_ADD    = 5'h00;
   localparam logic [4:0] OP_SUB    = 5'h01;
   localparam logic [4:0] OP_XOR    = 5'h02;
   localparam logic [4:0] OP_OR     = 5'h03;
   localparam logic [4:0] OP_AND    = 5'h04;
   localparam logic [4:0] OP_SLL    = 5'h05;
   localparam logic [4:0] OP_SRL    = 5'h06;
   localparam logic [4:0] OP_SRA    = 5'h07;
   localparam logic [4:0] OP_SLT    = 5'h08;
   localparam logic [4:0] OP_SLTU   = 5'h09;

   // M group
   localparam logic [4:0] OP_MUL    = 5'h10;
   localparam logic [4:0] OP_MULH   = 5'h11;
   localparam logic [4:0] OP_MULHSU = 5'h12;
   localparam logic [4:0] OP_MULHU  = 5'h13;
   localparam logic [4:0] OP_DIV    = 5'h14;
   localparam logic [4:0] OP_DIVU   = 5'h15;
   localparam logic [4:0] OP_REM    = 5'h16;
   localparam logic [4:0] OP_REMU   = 5'h17;

   // Low three bits of the M opcodes; bit 2 separates divide from multiply.
   typedef enum logic [2:0] {
      MDU_MUL    = 3'd0,
      MDU_MULH   = 3'd1,
      MDU_MULHSU = 3'd2,
      MDU_MULHU  = 3'd3,
      MDU_DIV    = 3'd4,
      MDU_DIVU   = 3'd5,
      MDU_REM    = 3'd6,
      MDU_REMU   = 3'd7
   } mdu_op_e;

   // MUL only needs the low half, so it can share the signed path.
   function automatic logic op_a_signed(input mdu_op_e op);
      return op inside {MDU_MUL, MDU_MULH, MDU_MULHSU, MDU_DIV, MDU_REM};
   endfunction

   function automatic logic op_b_signed(input mdu_op_e op);
      return op inside {MDU_MUL, MDU_MULH, MDU_DIV, MDU_REM};
   endfunction

   function automatic logic op_is_div(input mdu_op_e op);
      return op[2];
   endfunction

endpackage

// File: rtl/alu_mdu_if.sv
// -----------------------------------------------------------------------------
// alu_mdu_if
// Request/response bundle of the execute unit.
//   Request side : in_valid, in_ready, opcode, a, b
//   Response side: out_valid, out_ready, out
//   Status       : busy
// master = issue/writeback logic, slave = alu_mdu.
// -----------------------------------------------------------------------------
interface alu_mdu_if #(
   parameter int VAR_WIDTH = 32,
   parameter int OP_WIDTH  = 5
);
   logic                 in_valid;
   logic                 in_ready;
   logic [OP_WIDTH-1:0]  opcode;
   logic [VAR_WIDTH-1:0] a;
   logic [VAR_WIDTH-1:0] b;
   logic                 out_valid;
   logic                 out_ready;
   logic [VAR_WIDTH-1:0] out;
   logic                 busy;

   modport master (
      output in_valid, opcode, a, b, out_ready,
      input  in_ready, out_valid, out, busy
   );

   modport slave (
      input  in_valid, opcode, a, b, out_ready,
      output in_ready, out_valid, out, busy
   );
endinterface

// File: rtl/alu_mdu_iter.sv
// -----------------------------------------------------------------------------
// mdu_iter
// Iterative RV32M datapath: shift-add multiply and restoring divide on operand
// magnitudes, one bit per cycle for VAR_WIDTH cycles, followed by a sign
// fix-up. Owns the iteration counter, the {hi,lo} accumulator and the fix-up.
//
// Ports:
//   clk, rst   clock, synchronous active-high reset (aborts an operation)
//   start      load operands and begin (single cycle, only when idle)
//   op         mdu_op_e operation select
//   a, b       operands, sampled on start
//   done       high during the cycle whose rising edge performs the last
//              iteration; result is valid in that same cycle
//   result     fixed-up result, to be registered by the caller on done
// -----------------------------------------------------------------------------
module mdu_iter
   import alu_mdu_pkg::*;
#(
   parameter int VAR_WIDTH = 32
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 start,
   input  mdu_op_e              op,
   input  logic [VAR_WIDTH-1:0] a,
   input  logic [VAR_WIDTH-1:0] b,
   output logic                 done,
   output logic [VAR_WIDTH-1:0] result
);

   localparam int W     = VAR_WIDTH;
   localparam int CNT_W = $clog2(VAR_WIDTH + 1);

   logic             active;
   logic [CNT_W-1:0] cnt;
   mdu_op_e          op_q;
   logic [W-1:0]     hi;         // product high half / partial remainder
   logic [W-1:0]     lo;         // multiplier / dividend, becomes quotient
   logic [W-1:0]     operand_q;  // |b|: multiplicand or divisor
   logic             neg_q;      // product / quotient must be negated
   logic             a_neg_q;    // remainder must be negated
   logic             b_zero_q;

   logic             a_sgn, b_sgn;
   logic [W-1:0]     a_mag, b_mag;
   logic [W:0]       mul_sum;
   logic [W:0]       div_shift;
   logic [W:0]       div_diff;
   logic [W-1:0]     hi_n, lo_n;
   logic [2*W-1:0]   prod, prod_fix;
   logic [W-1:0]     quo_fix, rem_fix;

   always_comb begin
      a_sgn = op_a_signed(op) && a[W-1];
      b_sgn = op_b_signed(op) && b[W-1];
      a_mag = a_sgn ? -a : a;
      b_mag = b_sgn ? -b : b;
   end

   // One iteration step. Both engines are evaluated; op_q picks the one used.
   // NOTE: every always_comb output gets a default/full assignment on all
   // paths so that no latch is inferred.
   always_comb begin
      mul_sum   = {1'b0, hi} + (lo[0] ? {1'b0, operand_q} : '0);
      div_shift = {hi, lo[W-1]};
      div_diff  = div_shift - {1'b0, operand_q};
      hi_n      = mul_sum[W:1];
      lo_n      = {mul_sum[0], lo[W-1:1]};
      if (op_is_div(op_q)) begin
         // A borrow out of the trial subtraction means "restore".
         if (!div_diff[W]) begin
            hi_n = div_diff[W-1:0];
            lo_n = {lo[W-2:0], 1'b1};
         end else begin
            hi_n = div_shift[W-1:0];
            lo_n = {lo[W-2:0], 1'b0};
         end
      end
   end

   // Fix-up is taken from the step outputs so the result is ready in the
   // same cycle as the final iteration; no extra cycle for the sign fix.
   // A zero divisor leaves hi=|a| and lo=all ones on its own, so only the
   // quotient sign has to be suppressed; a=MIN, b=-1 wraps to MIN naturally.
   always_comb begin
      prod     = {hi_n, lo_n};
      prod_fix = neg_q ? -prod : prod;
      quo_fix  = b_zero_q ? '1 : (neg_q ? -lo_n : lo_n);
      rem_fix  = a_neg_q ? -hi_n : hi_n;
      case (op_q)
         MDU_MUL:                       result = prod_fix[W-1:0];
         MDU_MULH, MDU_MULHSU, MDU_MULHU: result = prod_fix[2*W-1:W];
         MDU_DIV, MDU_DIVU:             result = quo_fix;
         default:                       result = rem_fix;
      endcase
   end

   assign done = active && (cnt == CNT_W'(1));

   // NOTE: sequential state is assigned with non-blocking <= so every flop
   // samples pre-edge values regardless of statement order.
   always_ff @(posedge clk) begin
      if (rst) begin
         active <= 1'b0;
         cnt    <= '0;
      end else if (start) begin
         active <= 1'b1;
         cnt    <= CNT_W'(W);
      end else if (active) begin
         cnt <= cnt - CNT_W'(1);
         if (cnt == CNT_W'(1)) begin
            active <= 1'b0;
         end
      end
   end

   // NOTE: only control state is reset; the datapath registers are always
   // loaded on start before they are read, so resetting them buys nothing.
   always_ff @(posedge clk) begin
      if (start) begin
         op_q      <= op;
         hi        <= '0;
         lo        <= a_mag;
         operand_q <= b_mag;
         neg_q     <= a_sgn ^ b_sgn;
         a_neg_q   <= a_sgn;
         b_zero_q  <= (b == '0);
      end else if (active) begin
         hi <= hi_n;
         lo <= lo_n;
      end
   end

endmodule

// File: rtl/alu_mdu.sv
// -----------------------------------------------------------------------------
// alu_mdu
// Registered execute unit: single-cycle base ALU plus RV32M multiply/divide
// on the iterative mdu_iter engine, with valid/ready handshakes on both sides.
//
// Ports:
//   clk   clock, all state updates on the rising edge
//   rst   synchronous active-high reset; aborts any operation in flight
//   bus   alu_mdu_if.slave:
//           in_valid/in_ready/opcode/a/b   request (in_ready only in IDLE)
//           out_valid/out_ready/out        registered result handoff
//           busy                           high in BUSY or DONE
//
// Flow: IDLE -accept base/illegal-> DONE, IDLE -accept M op-> BUSY -> DONE,
//       DONE -out_ready-> IDLE. Undefined opcodes return 0 with latency 1.
// -----------------------------------------------------------------------------
module alu_mdu
   import alu_mdu_pkg::*;
#(
   parameter int VAR_WIDTH = 32,
   parameter int OP_WIDTH  = 5,
   parameter int SHAMT_W   = $clog2(VAR_WIDTH)
) (
   input  logic     clk,
   input  logic     rst,
   alu_mdu_if.slave bus
);

   localparam logic [1:0] ST_IDLE = 2'd0;
   localparam logic [1:0] ST_BUSY = 2'd1;
   localparam logic [1:0] ST_DONE = 2'd2;

   logic [1:0]           state;
   logic [VAR_WIDTH-1:0] out_q;
   logic                 out_valid_q;

   logic                 accept;
   logic                 is_mop;
   logic [SHAMT_W-1:0]   shamt;
   logic [VAR_WIDTH-1:0] base_res;
   logic                 mdu_done;
   logic [VAR_WIDTH-1:0] mdu_result;

   assign accept = bus.in_valid && (state == ST_IDLE);
   assign is_mop = (bus.opcode >= OP_WIDTH'(OP_MUL)) && (bus.opcode <= OP_WIDTH'(OP_REMU));
   assign shamt  = bus.b[SHAMT_W-1:0];

   // Base group; any code not listed (including undefined M codes) yields 0.
   always_comb begin
      base_res = '0;
      case (bus.opcode)
         OP_WIDTH'(OP_ADD):  base_res = bus.a + bus.b;
         OP_WIDTH'(OP_SUB):  base_res = bus.a - bus.b;
         OP_WIDTH'(OP_XOR):  base_res = bus.a ^ bus.b;
         OP_WIDTH'(OP_OR):   base_res = bus.a | bus.b;
         OP_WIDTH'(OP_AND):  base_res = bus.a & bus.b;
         OP_WIDTH'(OP_SLL):  base_res = bus.a << shamt;
         OP_WIDTH'(OP_SRL):  base_res = bus.a >> shamt;
         OP_WIDTH'(OP_SRA):  base_res = $signed(bus.a) >>> shamt;
         OP_WIDTH'(OP_SLT):  base_res = {{(VAR_WIDTH-1){1'b0}}, ($signed(bus.a) < $signed(bus.b))};
         OP_WIDTH'(OP_SLTU): base_res = {{(VAR_WIDTH-1){1'b0}}, (bus.a < bus.b)};
         default:            base_res = '0;
      endcase
   end

   mdu_iter #(
      .VAR_WIDTH (VAR_WIDTH)
   ) u_mdu_iter (
      .clk    (clk),
      .rst    (rst),
      .start  (accept && is_mop),
      .op     (mdu_op_e'(bus.opcode[2:0])),
      .a      (bus.a),
      .b      (bus.b),
      .done   (mdu_done),
      .result (mdu_result)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         state       <= ST_IDLE;
         out_q       <= '0;
         out_valid_q <= 1'b0;
      end else begin
         case (state)
            ST_IDLE: begin
               if (accept) begin
                  if (is_mop) begin
                     state <= ST_BUSY;
                  end else begin
                     out_q       <= base_res;
                     out_valid_q <= 1'b1;
                     state       <= ST_DONE;
                  end
               end
            end
            ST_BUSY: begin
               if (mdu_done) begin
                  out_q       <= mdu_result;
                  out_valid_q <= 1'b1;
                  state       <= ST_DONE;
               end
            end
            ST_DONE: begin
               if (bus.out_ready) begin
                  out_valid_q <= 1'b0;
                  state       <= ST_IDLE;
               end
            end
            default: begin
               state       <= ST_IDLE;
               out_valid_q <= 1'b0;
            end
         endcase
      end
   end

   assign bus.in_ready  = (state == ST_IDLE);
   assign bus.busy      = (state != ST_IDLE);
   assign bus.out       = out_q;
   assign bus.out_valid = out_valid_q;

endmodule

// File: tb/tb_alu_mdu.sv
// -----------------------------------------------------------------------------
// tb_alu_mdu
// Self-checking bench for alu_mdu: reset state, directed base/M vectors with
// hand-computed results and latencies, divide corner cases, illegal opcodes,
// output backpressure, reset mid-divide, and a constrained random sweep
// against a behavioural model.
// -----------------------------------------------------------------------------
module tb_alu_mdu;
   import alu_mdu_pkg::*;

   logic clk = 1'b0;
   logic rst;

   always #5 clk = ~clk;

   alu_mdu_if #(.VAR_WIDTH(32), .OP_WIDTH(5)) bus ();

   alu_mdu #(
      .VAR_WIDTH (32),
      .OP_WIDTH  (5)
   ) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   int n_cmp = 0;
   int n_bad = 0;

   typedef struct {
      logic [4:0]  op;
      logic [31:0] a;
      logic [31:0] b;
      logic [31:0] exp;
   } vec_t;

   vec_t        vecs[$];
   logic [4:0]  legal [18];

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   function automatic vec_t mk(input logic [4:0] op, input logic [31:0] a,
                               input logic [31:0] b, input logic [31:0] exp);
      vec_t v;
      v.op  = op;
      v.a   = a;
      v.b   = b;
      v.exp = exp;
      return v;
   endfunction

   // Behavioural reference for the random sweep.
   function automatic logic [31:0] model(input logic [4:0] op, input logic [31:0] a,
                                         input logic [31:0] b);
      logic [63:0]        p;
      logic [4:0]         sh;
      logic signed [31:0] sa;
      logic signed [31:0] sb;
      logic signed [31:0] sr;
      logic [31:0]        r;
      sh = b[4:0];
      sa = a;
      sb = b;
      r  = '0;
      case (op)
         5'h00: r = a + b;
         5'h01: r = a - b;
         5'h02: r = a ^ b;
         5'h03: r = a | b;
         5'h04: r = a & b;
         5'h05: r = a << sh;
         5'h06: r = a >> sh;
         5'h07: begin sr = sa >>> sh; r = sr; end
         5'h08: r = (sa < sb) ? 32'd1 : 32'd0;
         5'h09: r = (a < b) ? 32'd1 : 32'd0;
         5'h10: begin p = {32'b0, a} * {32'b0, b}; r = p[31:0]; end
         5'h11: begin p = {{32{a[31]}}, a} * {{32{b[31]}}, b}; r = p[63:32]; end
         5'h12: begin p = {{32{a[31]}}, a} * {32'b0, b}; r = p[63:32]; end
         5'h13: begin p = {32'b0, a} * {32'b0, b}; r = p[63:32]; end
         5'h14: begin
            if (b == 32'd0) r = 32'hFFFF_FFFF;
            else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) r = a;
            else begin sr = sa / sb; r = sr; end
         end
         5'h15: r = (b == 32'd0) ? 32'hFFFF_FFFF : a / b;
         5'h16: begin
            if (b == 32'd0) r = a;
            else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) r = 32'd0;
            else begin sr = sa % sb; r = sr; end
         end
         5'h17: r = (b == 32'd0) ? a : a % b;
         default: r = '0;
      endcase
      return r;
   endfunction

   function automatic logic [31:0] pick_operand();
      case ($urandom_range(0, 5))
         0:       return 32'h0000_0000;
         1:       return 32'h8000_0000;
         2:       return 32'hFFFF_FFFF;
         3:       return 32'h0000_0001;
         default: return $urandom;
      endcase
   endfunction

   // Issue one request from a negedge in IDLE. Returns the result, the latency
   // (1 = out_valid seen in the cycle right after the accept edge) and how many
   // post-accept samples showed in_ready high before the result appeared.
   task automatic issue(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b,
                        output logic [31:0] res, output int lat, output int rdy_hits);
      bus.in_valid = 1'b1;
      bus.opcode   = op;
      bus.a        = a;
      bus.b        = b;
      @(posedge clk);
      #1;
      bus.in_valid = 1'b0;
      bus.opcode   = 5'($urandom_range(0, 31));
      bus.a        = $urandom;
      bus.b        = $urandom;
      lat      = 1;
      rdy_hits = bus.in_ready ? 1 : 0;
      while (!bus.out_valid && lat < 200) begin
         @(posedge clk);
         #1;
         lat++;
         if (bus.in_ready) rdy_hits++;
      end
      res = bus.out;
   endtask

   task automatic run_vec(input string tag, input vec_t v);
      logic [31:0] res;
      int          lat;
      int          rdy_hits;
      int          exp_lat;
      exp_lat = (v.op[4] && !v.op[3]) ? 33 : 1;
      issue(v.op, v.a, v.b, res, lat, rdy_hits);
      check(tag, res, v.exp);
      check({tag, " latency"}, 32'(lat), 32'(exp_lat));
      check({tag, " in_ready while busy"}, 32'(rdy_hits), 32'd0);
      @(posedge clk);
      #1;
      check({tag, " back to idle"}, {30'b0, bus.in_ready, bus.out_valid}, 32'b10);
      @(negedge clk);
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [31:0] res;
      int          lat;
      int          rdy_hits;
      logic [31:0] held;
      vec_t        v;

      legal = '{5'h00, 5'h01, 5'h02, 5'h03, 5'h04, 5'h05, 5'h06, 5'h07, 5'h08, 5'h09,
                5'h10, 5'h11, 5'h12, 5'h13, 5'h14, 5'h15, 5'h16, 5'h17};

      rst           = 1'b1;
      bus.in_valid  = 1'b0;
      bus.opcode    = '0;
      bus.a         = '0;
      bus.b         = '0;
      bus.out_ready = 1'b1;
      repeat (3) @(posedge clk);
      @(negedge clk);
      check("reset out", bus.out, 32'd0);
      check("reset flags {in_ready,out_valid,busy}",
            {29'b0, bus.in_ready, bus.out_valid, bus.busy}, 32'b100);
      rst = 1'b0;
      @(negedge clk);

      // Directed vectors, expected values computed by hand.
      vecs.push_back(mk(OP_ADD,    32'h0000_0007, 32'hFFFF_FFFD, 32'h0000_0004));
      vecs.push_back(mk(OP_SUB,    32'h0000_0005, 32'h0000_0007, 32'hFFFF_FFFE));
      vecs.push_back(mk(OP_XOR,    32'hF0F0_F0F0, 32'hFF00_FF00, 32'h0FF0_0FF0));
      vecs.push_back(mk(OP_OR,     32'h0F00_0000, 32'h0000_00F0, 32'h0F00_00F0));
      vecs.push_back(mk(OP_AND,    32'hF0F0_F0F0, 32'hFF00_FF00, 32'hF000_F000));
      vecs.push_back(mk(OP_SLL,    32'h0000_0001, 32'h0000_0023, 32'h0000_0008));
      vecs.push_back(mk(OP_SRL,    32'h8000_0000, 32'h0000_001F, 32'h0000_0001));
      vecs.push_back(mk(OP_SRA,    32'h8000_0000, 32'h0000_0024, 32'hF800_0000));
      vecs.push_back(mk(OP_SLT,    32'hFFFF_FFFF, 32'h0000_0001, 32'h0000_0001));
      vecs.push_back(mk(OP_SLTU,   32'hFFFF_FFFF, 32'h0000_0001, 32'h0000_0000));
      vecs.push_back(mk(OP_MUL,    32'h1234_5678, 32'h0000_0010, 32'h2345_6780));
      vecs.push_back(mk(OP_MULH,   32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0000));
      vecs.push_back(mk(OP_MULHU,  32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE));
      vecs.push_back(mk(OP_MULHSU, 32'hFFFF_FFFF, 32'h0000_0002, 32'hFFFF_FFFF));
      vecs.push_back(mk(OP_DIV,    32'hFFFF_FFF9, 32'h0000_0002, 32'hFFFF_FFFD));
      vecs.push_back(mk(OP_REM,    32'hFFFF_FFF9, 32'h0000_0002, 32'hFFFF_FFFF));
      vecs.push_back(mk(OP_DIVU,   32'h0000_0007, 32'h0000_0000, 32'hFFFF_FFFF));
      vecs.push_back(mk(OP_REMU,   32'h0000_0007, 32'h0000_0000, 32'h0000_0007));
      vecs.push_back(mk(OP_DIV,    32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000));
      vecs.push_back(mk(OP_REM,    32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000));
      vecs.push_back(mk(OP_DIV,    32'hFFFF_FFF9, 32'h0000_0000, 32'hFFFF_FFFF));
      vecs.push_back(mk(OP_REM,    32'hFFFF_FFF9, 32'h0000_0000, 32'hFFFF_FFF9));
      vecs.push_back(mk(5'h1F,     32'h1234_5678, 32'h0000_0010, 32'h0000_0000));
      vecs.push_back(mk(5'h0A,     32'h0000_0003, 32'h0000_0004, 32'h0000_0000));
      vecs.push_back(mk(5'h18,     32'h0000_0003, 32'h0000_0004, 32'h0000_0000));

      foreach (vecs[i]) begin
         run_vec($sformatf("dir%0d op%02h", i, vecs[i].op), vecs[i]);
      end

      // Backpressure: result and flags hold, a new request is ignored.
      bus.out_ready = 1'b0;
      issue(OP_MUL, 32'h1234_5678, 32'h0000_0010, res, lat, rdy_hits);
      check("bp result", res, 32'h2345_6780);
      check("bp latency", 32'(lat), 32'd33);
      held = res;
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         bus.in_valid = 1'b1;
         bus.opcode   = OP_ADD;
         bus.a        = 32'd5;
         bus.b        = 32'd5;
         @(posedge clk);
         #1;
         check($sformatf("bp hold out %0d", i), bus.out, held);
         check($sformatf("bp hold flags %0d", i),
               {29'b0, bus.in_ready, bus.out_valid, bus.busy}, 32'b011);
      end
      @(negedge clk);
      bus.in_valid  = 1'b0;
      bus.out_ready = 1'b1;
      @(posedge clk);
      #1;
      check("bp release flags", {29'b0, bus.in_ready, bus.out_valid, bus.busy}, 32'b100);
      repeat (3) @(posedge clk);
      #1;
      check("bp ignored request", {30'b0, bus.in_ready, bus.out_valid}, 32'b10);
      check("bp out after release", bus.out, held);
      @(negedge clk);

      // Reset ten cycles into a divide.
      bus.in_valid = 1'b1;
      bus.opcode   = OP_DIV;
      bus.a        = 32'hFFFF_FFF9;
      bus.b        = 32'h0000_0002;
      @(posedge clk);
      #1;
      bus.in_valid = 1'b0;
      repeat (10) @(posedge clk);
      #1;
      rst = 1'b1;
      @(posedge clk);
      #1;
      check("abort out", bus.out, 32'd0);
      check("abort flags", {29'b0, bus.in_ready, bus.out_valid, bus.busy}, 32'b100);
      rst = 1'b0;
      @(negedge clk);
      run_vec("post-abort add", mk(OP_ADD, 32'd1, 32'd1, 32'd2));

      // Constrained random sweep against the model.
      for (int i = 0; i < 30; i++) begin
         v.op  = legal[$urandom_range(0, 17)];
         v.a   = pick_operand();
         v.b   = pick_operand();
         v.exp = model(v.op, v.a, v.b);
         run_vec($sformatf("rnd%0d op%02h a%h b%h", i, v.op, v.a, v.b), v);
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
